// File: rtl/seg_disp_arb_pkg.sv
// seg_disp_arb_pkg
//   Shared definitions for the display arbiter slice: display and channel
//   widths, the arbiter state type and the round-robin pointer helper.
//   Imported by rr_pick and seg_disp_arb.
package seg_disp_arb_pkg;

  // Width of the binary value handed to the BCD / 7-seg driver
  localparam int DISP_W = 8;

  // Channel index width; covers the full 1..8 requester range
  localparam int CH_W = 3;

  // Arbiter states: IDLE shows the default channel live, HOLD shows a latched value
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Channel after idx, wrapping at n so the search rotates fairly
  function automatic logic [CH_W-1:0] nextRr(input logic [CH_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/seg_disp_arb_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker. Scans the request vector
//   starting at i_ptr and wrapping at N. Returns the first requester found.
// Ports
//   i_req     in   N     request levels
//   i_ptr     in   3     channel the scan starts from (must be < N)
//   o_gnt     out  N     one-hot winner, zero when nothing requests
//   o_gntIdx  out  3     index of the winner (0 when nothing requests)
//   o_any     out  1     at least one request present
module rr_pick
  import seg_disp_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [CH_W-1:0] o_gntIdx,
  output logic            o_any
);

  logic [7:0] w_reqPad;
  logic [7:0] w_gntPad;

  // Requests are padded to eight lanes so every channel select uses an
  // exact 3-bit index, whatever N is
  assign w_reqPad = 8'(i_req);

  // Walk the channels in rotated order from i_ptr. The first requester
  // found wins, and later matches are ignored once o_any is set
  always_comb begin
    logic [CH_W-1:0] k;
    int              kInt;
    w_gntPad = '0;
    o_gntIdx = '0;
    o_any    = 1'b0;
    k        = '0;
    kInt     = 0;
    for (int i = 0; i < N; i++) begin
      kInt = (int'(i_ptr) + i) % N;
      k    = CH_W'(kInt);
      if (!o_any && w_reqPad[k]) begin
        o_any       = 1'b1;
        w_gntPad[k] = 1'b1;
        o_gntIdx    = k;
      end
    end
  end

  assign o_gnt = w_gntPad[N-1:0];

endmodule

// File: rtl/seg_disp_arb.sv
// seg_disp_arb
//   Shares one 8-bit decimal display path between N value sources. When
//   idle, the display shows the default channel live. A request takes the
//   display for a timed hold of HOLD_TICKS tick strobes. When the hold
//   expires, the display goes to the next pending request in round-robin
//   order, or falls back to the default channel if nothing is pending.
//   Optional build macro SEG_ARB_BLINK_EN: blank toggles every BLINK_TICKS
//   ticks while holding. Without the macro, blank is tied low.
// Ports
//   i_clk        in   1      system clock
//   i_rst        in   1      synchronous reset, active-high
//   i_tick       in   1      one-cycle timebase strobe
//   i_req        in   N      level request per channel, held until ack
//   i_val        in   8*N    channel values, channel k at [8k+7:8k]
//   o_ack        out  N      one-cycle grant pulse
//   o_bin_out    out  8      registered value for the display driver
//   o_active_ch  out  3      channel currently shown
//   o_busy       out  1      high while holding
//   o_blank      out  1      display blank request
module seg_disp_arb
  import seg_disp_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int HOLD_TICKS  = 2000,
  parameter int DEF_CH      = 0,
  parameter int BLINK_TICKS = 250
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic [N-1:0]        i_req,
  input  logic [DISP_W*N-1:0] i_val,
  output logic [N-1:0]        o_ack,
  output logic [DISP_W-1:0]   o_bin_out,
  output logic [CH_W-1:0]     o_active_ch,
  output logic                o_busy,
  output logic                o_blank
);

  localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CH_W-1:0] DEF_IDX = CH_W'(DEF_CH);

  state_t              r_state;
  state_t              w_stateNext;
  logic [N-1:0]        r_ack;
  logic [N-1:0]        w_ackNext;
  logic [DISP_W-1:0]   r_binOut;
  logic [DISP_W-1:0]   w_binNext;
  logic [CH_W-1:0]     r_activeCh;
  logic [CH_W-1:0]     w_activeNext;
  logic                r_busy;
  logic                w_busyNext;
  logic [CNT_W-1:0]    r_holdCnt;
  logic [CNT_W-1:0]    w_holdNext;
  logic [CH_W-1:0]     r_rrPtr;
  logic [CH_W-1:0]     w_rrNext;

  logic [N-1:0]        w_reqEff;
  logic [7:0]          w_reqPad;
  logic [N-1:0]        w_pickGnt;
  logic [CH_W-1:0]     w_pickIdx;
  logic                w_pickAny;
  logic                w_grant;
  logic [CH_W-1:0]     w_grantIdx;
  logic [7:0]          w_ackPad;
  logic [DISP_W*8-1:0] w_valPad;
  logic [DISP_W-1:0]   w_defVal;
  logic [DISP_W-1:0]   w_grantVal;

  // A request is still high during its own ack cycle, because the source
  // only sees the ack then. Masking it with the outstanding ack stops the
  // same request from being granted twice
  assign w_reqEff = i_req & ~r_ack;
  assign w_reqPad = 8'(w_reqEff);

  // Values are padded to eight lanes so that channel selects use exact indices
  assign w_valPad   = (DISP_W*8)'(i_val);
  assign w_defVal   = w_valPad[{DEF_IDX, 3'b000} +: DISP_W];
  assign w_grantVal = w_valPad[{w_grantIdx, 3'b000} +: DISP_W];
  assign w_ackPad   = 8'b1 << w_grantIdx;

  rr_pick #(
    .N(N)
  ) u_rrPick (
    .i_req   (w_reqEff),
    .i_ptr   (r_rrPtr),
    .o_gnt   (w_pickGnt),
    .o_gntIdx(w_pickIdx),
    .o_any   (w_pickAny)
  );

  // State and output registers. Every output comes straight from a flop, so
  // a request seen in one cycle shows up at the outputs in the next cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ack      <= '0;
      r_binOut   <= '0;
      r_activeCh <= DEF_IDX;
      r_busy     <= 1'b0;
      r_holdCnt  <= '0;
      r_rrPtr    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_ack      <= w_ackNext;
      r_binOut   <= w_binNext;
      r_activeCh <= w_activeNext;
      r_busy     <= w_busyNext;
      r_holdCnt  <= w_holdNext;
      r_rrPtr    <= w_rrNext;
    end
  end

  // Next-state logic. A same-channel request in HOLD is checked before the
  // tick, so a re-request beats a simultaneous expiry, and a fresh reload
  // ignores the tick that arrives with it. Every grant path then shares one
  // block that latches the value, reloads the hold and moves the pointer
  always_comb begin
    w_stateNext  = r_state;
    w_ackNext    = '0;
    w_binNext    = r_binOut;
    w_activeNext = r_activeCh;
    w_busyNext   = r_busy;
    w_holdNext   = r_holdCnt;
    w_rrNext     = r_rrPtr;
    w_grant      = 1'b0;
    w_grantIdx   = w_pickIdx;
    case (r_state)
      ST_IDLE: begin
        w_binNext    = w_defVal;
        w_activeNext = DEF_IDX;
        w_busyNext   = 1'b0;
        if (w_pickAny) begin
          w_grant = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_reqPad[r_activeCh]) begin
          w_grant    = 1'b1;
          w_grantIdx = r_activeCh;
        end else if (i_tick) begin
          if (r_holdCnt == '0) begin
            if (w_pickAny) begin
              w_grant = 1'b1;
            end else begin
              w_stateNext  = ST_IDLE;
              w_binNext    = w_defVal;
              w_activeNext = DEF_IDX;
              w_busyNext   = 1'b0;
            end
          end else begin
            w_holdNext = r_holdCnt - 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
    if (w_grant) begin
      w_stateNext  = ST_HOLD;
      w_ackNext    = w_ackPad[N-1:0];
      w_binNext    = w_grantVal;
      w_activeNext = w_grantIdx;
      w_busyNext   = 1'b1;
      w_holdNext   = HOLD_LOAD;
      w_rrNext     = nextRr(w_grantIdx, N);
    end
  end

`ifdef SEG_ARB_BLINK_EN
  localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_TICKS - 1);

  logic [BL_W-1:0] r_blinkCnt;
  logic            r_blank;

  // Blink phase restarts unblanked on every grant and stays cleared in
  // IDLE. While holding, the phase flips after each BLINK_TICKS ticks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blinkCnt <= '0;
      r_blank    <= 1'b0;
    end else if (w_grant || w_stateNext == ST_IDLE) begin
      r_blinkCnt <= '0;
      r_blank    <= 1'b0;
    end else if (i_tick) begin
      if (r_blinkCnt == BLINK_LAST) begin
        r_blinkCnt <= '0;
        r_blank    <= ~r_blank;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  assign o_blank = r_blank;
`else
  // Without blinking the display is never blanked. BLINK_TICKS is only
  // referenced here so the parameter stays part of the interface
  assign o_blank = 1'b0 && (BLINK_TICKS > 0);
`endif

  assign o_ack       = r_ack;
  assign o_bin_out   = r_binOut;
  assign o_active_ch = r_activeCh;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_seg_disp_arb.sv
// tb_seg_disp_arb
//   Directed bench for seg_disp_arb (N=4, HOLD_TICKS=2000, DEF_CH=0,
//   BLINK_TICKS=4). Each expected grant is queued when its request is driven.
//   The queued entry is popped and compared when the ack pulse appears.
//   The blank checks follow SEG_ARB_BLINK_EN when the bench is built with it.
module tb_seg_disp_arb;

  localparam int HOLD = 2000;
  localparam bit BLINK_ON =
`ifdef SEG_ARB_BLINK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  req  = '0;
  logic [31:0] val  = '0;
  logic [3:0]  ack;
  logic [7:0]  binOut;
  logic [2:0]  activeCh;
  logic        busy;
  logic        blank;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] ack;
    logic [2:0] ch;
    logic [7:0] v;
  } expT;

  expT expQ[$];

  seg_disp_arb #(
    .N          (4),
    .HOLD_TICKS (HOLD),
    .DEF_CH     (0),
    .BLINK_TICKS(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tick     (tick),
    .i_req      (req),
    .i_val      (val),
    .o_ack      (ack),
    .o_bin_out  (binOut),
    .o_active_ch(activeCh),
    .o_busy     (busy),
    .o_blank    (blank)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Stops the run if it stalls somewhere
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic t);
    req  = r;
    tick = t;
  endtask

  task automatic setVal(input int ch, input logic [7:0] v);
    val[ch*8 +: 8] = v;
  endtask

  task automatic expectGrant(input int ch);
    expT e;
    e.ack = 4'(1 << ch);
    e.ch  = 3'(ch);
    e.v   = val[ch*8 +: 8];
    expQ.push_back(e);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  task automatic waitAck(input string tag);
    int  k;
    expT e;
    k = 0;
    while (ack == 4'b0 && k < 8) begin
      cyc();
      k++;
    end
    checkOutput({tag, "_ackSeen"}, {31'd0, ack != 4'b0}, 32'd1);
    checkOutput({tag, "_qDepth"}, expQ.size() > 0 ? 32'd1 : 32'd0, 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_ack"}, ack, e.ack);
      checkOutput({tag, "_bin"}, binOut, e.v);
      checkOutput({tag, "_ch"}, activeCh, e.ch);
      checkOutput({tag, "_busy"}, busy, 1);
      checkOutput({tag, "_blank"}, blank, 0);
    end
    req = req & ~ack;
  endtask

  initial begin
    $display("[TB] start");
    // Reset state
    cyc();
    cyc();
    checkOutput("rstBin", binOut, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstCh", activeCh, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstBlank", blank, 0);

    // Idle shows channel 0 live
    setVal(0, 42);
    rst = 1'b0;
    cyc();
    checkOutput("idleBin42", binOut, 42);
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleCh", activeCh, 0);
    setVal(0, 43);
    cyc();
    checkOutput("idleBin43", binOut, 43);

    // Single request, full hold, blink phase, fall back to idle
    setVal(2, 200);
    expectGrant(2);
    applyStimulus(4'b0100, 1'b0);
    cyc();
    waitAck("t2grant");
    cyc();
    checkOutput("t2AckPulse", ack, 0);
    setVal(2, 99);
    runTicks(4);
    checkOutput("t2Blank1", blank, BLINK_ON ? 1 : 0);
    runTicks(4);
    checkOutput("t2Blank2", blank, 0);
    runTicks(4);
    checkOutput("t2Blank3", blank, BLINK_ON ? 1 : 0);
    checkOutput("t2Latched", binOut, 200);
    runTicks(HOLD - 13);
    checkOutput("t2StillBusy", busy, 1);
    checkOutput("t2StillCh", activeCh, 2);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checkOutput("t2ExpBusy", busy, 0);
    checkOutput("t2ExpBin", binOut, 43);
    checkOutput("t2ExpCh", activeCh, 0);
    checkOutput("t2ExpBlank", blank, 0);

    // Two simultaneous requests: rr pointer at 3 picks ch1, then ch2 on expiry
    setVal(1, 11);
    setVal(2, 22);
    expectGrant(1);
    expectGrant(2);
    applyStimulus(4'b0110, 1'b0);
    cyc();
    waitAck("t3first");
    runTicks(HOLD - 1);
    checkOutput("t3HoldBusy", busy, 1);
    checkOutput("t3HoldCh", activeCh, 1);
    checkOutput("t3NoEarlyAck", ack, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    waitAck("t3second");

    // Re-request mid-hold restarts the hold; re-request on expiry tick too
    cyc();
    runTicks(1500);
    checkOutput("t4MidBusy", busy, 1);
    setVal(2, 33);
    expectGrant(2);
    applyStimulus(4'b0100, 1'b0);
    cyc();
    waitAck("t4reReq");
    runTicks(HOLD - 1);
    checkOutput("t4Busy", busy, 1);
    checkOutput("t4Bin", binOut, 33);
    setVal(2, 34);
    expectGrant(2);
    applyStimulus(4'b0100, 1'b1);
    cyc();
    tick = 1'b0;
    waitAck("t4expiryReq");
    cyc();
    checkOutput("t4NoIdleBusy", busy, 1);
    checkOutput("t4NoIdleCh", activeCh, 2);
    runTicks(HOLD - 1);
    checkOutput("t4LateBusy", busy, 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checkOutput("t4ExpBusy", busy, 0);
    checkOutput("t4ExpCh", activeCh, 0);

    // Reset mid-hold, then the pending request is granted right after
    setVal(3, 77);
    expectGrant(3);
    applyStimulus(4'b1000, 1'b0);
    cyc();
    waitAck("t5grant");
    runTicks(10);
    setVal(1, 55);
    applyStimulus(4'b0010, 1'b0);
    rst = 1'b1;
    cyc();
    checkOutput("t5RstBin", binOut, 0);
    checkOutput("t5RstAck", ack, 0);
    checkOutput("t5RstCh", activeCh, 0);
    checkOutput("t5RstBusy", busy, 0);
    checkOutput("t5RstBlank", blank, 0);
    rst = 1'b0;
    expectGrant(1);
    cyc();
    checkOutput("t5NextCycleAck", ack, 4'b0010);
    waitAck("t5pending");

    // Round-robin at expiry: pointer at 2 picks ch3 over ch0, then ch0 itself holds
    runTicks(HOLD - 1);
    setVal(3, 78);
    expectGrant(3);
    applyStimulus(4'b1001, 1'b1);
    cyc();
    tick = 1'b0;
    waitAck("t5rr");
    runTicks(HOLD - 1);
    expectGrant(0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    waitAck("t5defCh");
    runTicks(HOLD - 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checkOutput("t5FinalBusy", busy, 0);
    checkOutput("t5FinalBin", binOut, 43);
    checkOutput("qDrained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
